// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage. Owns the program counter and drives the
//            instruction-memory byte address from it. Latches the returned
//            instruction into the IF/ID register. Handles hazard stalls,
//            redirects (one bubble) and a HALT state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous active-low reset
//   stall          in   1   hold PC and IF/ID (RUN only)
//   flush          in   1   redirect PC to target, insert bubble
//   target         in   8   redirect byte address
//   halt_req       in   1   enter HALT (RUN only, flush has priority)
//   imem_addr      out  8   byte address to instruction memory (= PC reg)
//   imem_data      in   32  combinational instruction for imem_addr
//   ifid_instr     out  32  latched instruction
//   ifid_pc        out  8   PC of ifid_instr
//   ifid_pc_plus4  out  8   ifid_pc + 4 (mod 256)
//   ifid_valid     out  1   ifid_instr is a real fetched instruction
//   halted         out  1   high while in HALT
//   fetch_count    out  16  saturating count of valid instructions latched
//   misalign_err   out  1   sticky misaligned-redirect flag
//                           (only with FETCH_ALIGN_CHECK_EN)
// Build option:
//   FETCH_ALIGN_CHECK_EN - when defined, redirect targets are word-aligned
//                          and misaligned redirects set misalign_err.
// ============================================================================
module fetch_stage #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [7:0]  target,
  input  logic        halt_req,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [7:0]  ifid_pc,
  output logic [7:0]  ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign_err,
`endif
  output logic [15:0] fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  ipc_q, ipc_d;
  logic [7:0]  ipc4_q, ipc4_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        mis_q, mis_d;
`endif

  // Priority: flush > halt_req > stall > normal fetch. HALT holds everything
  // until a flush (or reset) brings the stage back to RUN.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    valid_d = valid_q;
    count_d = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_d   = mis_q;
`endif
    if (flush) begin
      state_d = ST_RUN;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d = {target[7:2], 2'b00};
      if (target[1:0] != 2'b00) begin
        mis_d = 1'b1;
      end
`else
      // Word-addressed memory ignores bits [1:0]; keep target as given.
      pc_d = target;
`endif
    end else if (state_q == ST_RUN) begin
      if (halt_req) begin
        state_d = ST_HALT;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = imem_data;
        ipc_d   = pc_q;
        ipc4_d  = pc_q + 8'd4;
        valid_d = 1'b1;
        pc_d    = pc_q + 8'd4;
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ipc_q   <= 8'h00;
      ipc4_q  <= 8'h00;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
`ifdef FETCH_ALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc       = ipc_q;
  assign ifid_pc_plus4 = ipc4_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == ST_HALT);
  assign fetch_count   = count_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_err  = mis_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Scoreboard bench for fetch_stage. The driver issues one input
//            vector per cycle and pushes the hand-computed post-edge state;
//            the monitor pops and compares after every rising edge.
//            Memory model: word n at byte address 4n holds 32'h1000_0000+n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [7:0]  target;
  logic        halt_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc;
  logic [7:0]  ifid_pc_plus4;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
  localparam logic C_ALIGN = 1'b1;
`else
  logic        misalign_err;
  assign misalign_err = 1'b0;
  localparam logic C_ALIGN = 1'b0;
`endif

  fetch_stage #(.RESET_PC(8'h00), .NOP_INSTR(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .flush         (flush),
    .target        (target),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
`ifdef FETCH_ALIGN_CHECK_EN
    .misalign_err  (misalign_err),
`endif
    .fetch_count   (fetch_count)
  );

  assign imem_data = 32'h1000_0000 + {26'd0, imem_addr[7:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic [7:0]  pc4;
    logic        valid;
    logic        halted;
    logic [15:0] count;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int   tests;
  int   fails;
  int   vec_id;
  int   mon_id;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  task automatic chk_all(input int id, input exp_t e);
    chk("imem_addr", id, {24'd0, imem_addr}, {24'd0, e.addr});
    chk("ifid_instr", id, ifid_instr, e.instr);
    chk("ifid_pc", id, {24'd0, ifid_pc}, {24'd0, e.pc});
    chk("ifid_pc_plus4", id, {24'd0, ifid_pc_plus4}, {24'd0, e.pc4});
    chk("ifid_valid", id, {31'd0, ifid_valid}, {31'd0, e.valid});
    chk("halted", id, {31'd0, halted}, {31'd0, e.halted});
    chk("fetch_count", id, {16'd0, fetch_count}, {16'd0, e.count});
    if (C_ALIGN) begin
      chk("misalign_err", id, {31'd0, misalign_err}, {31'd0, e.mis});
    end
  endtask

  // Monitor: compares the DUT state after every rising edge that has an
  // outstanding expectation.
  initial begin
    mon_id = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        chk_all(mon_id, sb_q.pop_front());
        mon_id++;
      end
    end
  end

  task automatic step(input logic s, input logic f, input logic [7:0] t,
                      input logic h, input logic [7:0] addr,
                      input logic [31:0] instr, input logic [7:0] pc,
                      input logic [7:0] pc4, input logic v, input logic hl,
                      input logic [15:0] cnt, input logic mis);
    exp_t e;
    @(negedge clk);
    stall = s; flush = f; target = t; halt_req = h;
    e = '{addr, instr, pc, pc4, v, hl, cnt, mis};
    sb_q.push_back(e);
    vec_id++;
    @(posedge clk);
  endtask

  localparam exp_t C_RST = '{8'h00, 32'h0, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0, 1'b0};

  logic [7:0]  p;
  logic [7:0]  a13;
  int          wait_cyc;

  initial begin
    tests = 0; fails = 0; vec_id = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; target = 8'h00; halt_req = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk_all(-1, C_RST);
    rst_n = 1'b1;

    // free-running fetches to pc=08
    step(0,0,8'h00,0, 8'h04, 32'h1000_0000, 8'h00, 8'h04, 1,0, 16'd1, 0);
    step(0,0,8'h00,0, 8'h08, 32'h1000_0001, 8'h04, 8'h08, 1,0, 16'd2, 0);
    // stall 3 cycles at pc=08: everything holds
    step(1,0,8'h00,0, 8'h08, 32'h1000_0001, 8'h04, 8'h08, 1,0, 16'd2, 0);
    step(1,0,8'h00,0, 8'h08, 32'h1000_0001, 8'h04, 8'h08, 1,0, 16'd2, 0);
    step(1,0,8'h00,0, 8'h08, 32'h1000_0001, 8'h04, 8'h08, 1,0, 16'd2, 0);
    // resume at 08
    step(0,0,8'h00,0, 8'h0C, 32'h1000_0002, 8'h08, 8'h0C, 1,0, 16'd3, 0);
    step(0,0,8'h00,0, 8'h10, 32'h1000_0003, 8'h0C, 8'h10, 1,0, 16'd4, 0);
    // flush + stall: flush wins, bubble, ifid_pc holds
    step(1,1,8'h40,0, 8'h40, 32'h0,         8'h0C, 8'h10, 0,0, 16'd4, 0);
    step(0,0,8'h00,0, 8'h44, 32'h1000_0010, 8'h40, 8'h44, 1,0, 16'd5, 0);
    // wrap at FC
    step(0,1,8'hFC,0, 8'hFC, 32'h0,         8'h40, 8'h44, 0,0, 16'd5, 0);
    step(0,0,8'h00,0, 8'h00, 32'h1000_003F, 8'hFC, 8'h00, 1,0, 16'd6, 0);
    step(0,0,8'h00,0, 8'h04, 32'h1000_0000, 8'h00, 8'h04, 1,0, 16'd7, 0);
    // halt and hold under stall / halt_req toggling
    step(0,0,8'h00,1, 8'h04, 32'h0,         8'h00, 8'h04, 0,1, 16'd7, 0);
    step(1,0,8'h00,0, 8'h04, 32'h0,         8'h00, 8'h04, 0,1, 16'd7, 0);
    step(0,0,8'h00,1, 8'h04, 32'h0,         8'h00, 8'h04, 0,1, 16'd7, 0);
    step(1,0,8'h00,1, 8'h04, 32'h0,         8'h00, 8'h04, 0,1, 16'd7, 0);
    step(0,0,8'h00,0, 8'h04, 32'h0,         8'h00, 8'h04, 0,1, 16'd7, 0);
    // flush + halt_req out of HALT: flush wins, RUN
    step(0,1,8'h20,1, 8'h20, 32'h0,         8'h00, 8'h04, 0,0, 16'd7, 0);
    step(0,0,8'h00,0, 8'h24, 32'h1000_0008, 8'h20, 8'h24, 1,0, 16'd8, 0);
    // halt_req + stall: halt wins
    step(1,0,8'h00,1, 8'h24, 32'h0,         8'h20, 8'h24, 0,1, 16'd8, 0);
    // misaligned redirect to 13
    a13 = C_ALIGN ? 8'h10 : 8'h13;
    step(0,1,8'h13,0, a13,   32'h0,         8'h20, 8'h24, 0,0, 16'd8, C_ALIGN);
    p = a13;
    for (int i = 0; i < 11; i++) begin
      step(0,0,8'h00,0, p + 8'd4, 32'h1000_0000 + {26'd0, p[7:2]}, p, p + 8'd4,
           1,0, 16'd9 + 16'(i), C_ALIGN);
      p = p + 8'd4;
    end

    // drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end

    // asynchronous reset mid-cycle while stalled: no clock edge needed
    @(negedge clk);
    #2;
    stall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all(-2, C_RST);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
